face_detect_feature_acc: RTL and testbench
==========================================

FACE_DETECT_FEATURE_ACC -- requirements
Module: face_detect_feature_acc

Interface
REQ-001 SHALL have parameter PROD_W, default 22, width of unsigned product input.
REQ-002 SHALL have parameter ACC_W, default 26, signed accumulator/threshold width (ACC_W > PROD_W).
REQ-003 SHALL have parameter MAX_RECT, default 16, maximum products per feature.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  product beat valid.
REQ-007 in_ready  output  1  block accepts beat.
REQ-008 in_prod  input  PROD_W  unsigned rectangle-sum x weight product from the upstream multiplier.
REQ-009 in_neg  input  1  1 = subtract product, 0 = add.
REQ-010 in_last  input  1  final product of current feature.
REQ-011 thr  input  ACC_W  signed feature threshold, sampled on first beat of a feature.
REQ-012 out_valid  output  1  feature result valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_sum  output  ACC_W  signed accumulated feature sum.
REQ-015 out_pass  output  1  out_sum >= latched thr (signed compare).
REQ-016 out_err  output  1  feature force-terminated at MAX_RECT without in_last.
REQ-017 out_ovf  output  1  accumulator saturated during feature.

Function
REQ-018 SHALL implement states IDLE, ACCUM, HOLD; beat accepted when in_valid && in_ready.
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD (decoded from registered state).
REQ-020 IDLE + accepted beat: acc <= 0 +/- zero-extended in_prod, thr latched, rect count <= 1; go ACCUM, or HOLD if in_last.
REQ-021 ACCUM + accepted beat: acc <= acc +/- zero-extended in_prod, count increments; no beat leaves state unchanged.
REQ-022 Accepted beat with in_last, or beat making count equal MAX_RECT, SHALL transition to HOLD; the latter with in_last=0 sets out_err.
REQ-023 out_valid SHALL assert the cycle after the terminating beat and hold with out_sum/out_pass/out_err/out_ovf stable until out_valid && out_ready.
REQ-024 HOLD + out_ready SHALL return to IDLE; next beat accepted no earlier than the following cycle (one-cycle bubble).
REQ-025 Without saturation (see REQ-031), arithmetic SHALL wrap modulo 2^ACC_W.
REQ-026 out_pass SHALL be computed from the final (saturated or wrapped) sum.

Reset
REQ-027 reset_n low SHALL asynchronously force state IDLE, acc 0, count 0, latched thr 0.
REQ-028 During reset out_valid=0, out_sum=0, out_pass=0, out_err=0, out_ovf=0; in_ready=1 after release.
REQ-029 Reset mid-feature or in HOLD SHALL discard the partial/pending result with no out_valid pulse.

Configuration
REQ-030 Macro FACE_DETECT_ACC_SAT_EN SHALL select saturation.
REQ-031 Defined: each add/subtract clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and sets out_ovf for that feature (cleared on IDLE entry).
REQ-032 Undefined: wrapping per REQ-025, out_ovf tied 0, no saturation logic.

Verification
REQ-033 Beats (1000,+),(300,-),(200,+,last), thr=850 -> out_valid next cycle, out_sum=900, out_pass=1, out_err=0.
REQ-034 Same beats, thr=901 -> out_sum=900, out_pass=0; thr=-5 with single (5,-,last) -> out_sum=-5, out_pass=1.
REQ-035 16 beats of 1, in_last=0 -> HOLD after 16th, out_sum=16, out_err=1; 17th beat stalled (in_ready=0).
REQ-036 out_ready held 0 for 5 cycles -> outputs stable, in_ready=0; out_ready=1 -> IDLE, new feature accepted next cycle.
REQ-037 Nine beats of 4194303 (+), last on ninth -> with FACE_DETECT_ACC_SAT_EN: out_sum=33554431, out_ovf=1; without: out_sum=-29360137, out_ovf=0.
REQ-038 reset_n pulsed low after 2 beats of a feature -> no out_valid; next feature (7,+,last) yields out_sum=7.

Source files
------------

// File: rtl/face_detect_feature_acc.sv
// face_detect_feature_acc
// Accumulates signed rectangle-sum x weight products for one Haar-like
// feature and compares the final sum with a per-feature threshold.
// A feature ends on in_last or when MAX_RECT products have arrived; the
// result is held until the downstream handshake completes.
// Build option: define FACE_DETECT_ACC_SAT_EN to clamp every add/subtract
// to the signed ACC_W range and report it on out_ovf; otherwise the
// accumulator wraps modulo 2^ACC_W and out_ovf is tied low.
module face_detect_feature_acc #(
  parameter int PROD_W   = 22,
  parameter int ACC_W    = 26,
  parameter int MAX_RECT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_neg,
  input  logic              in_last,
  input  logic [ACC_W-1:0]  thr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_pass,
  output logic              out_err,
  output logic              out_ovf
);

  localparam int CNT_W = $clog2(MAX_RECT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RECT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_thr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic               r_pass;
  logic               r_err;

  logic               w_first;
  logic               w_accept;
  logic [ACC_W-1:0]   w_acc_base;
  logic [ACC_W-1:0]   w_thr_eff;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [ACC_W-1:0]   w_sum;
  logic               w_pass;
  logic               w_term;

  // Ready is a pure decode of the registered state: only HOLD stalls input.
  assign in_ready   = (r_state != ST_HOLD);
  assign w_accept   = in_valid && in_ready;
  // The first beat of a feature starts from zero and uses the live threshold.
  assign w_first    = (r_state == ST_IDLE);
  assign w_acc_base = w_first ? {ACC_W{1'b0}} : r_acc;
  assign w_thr_eff  = w_first ? thr : r_thr;
  assign w_cnt_next = (w_first ? {CNT_W{1'b0}} : r_cnt) + CNT_ONE;
  assign w_prod_ext = {{(ACC_W-PROD_W){1'b0}}, in_prod};
  assign w_pass     = ($signed(w_sum) >= $signed(w_thr_eff));
  assign w_term     = in_last || (w_cnt_next == CNT_MAX);

`ifdef FACE_DETECT_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] w_wide;
  logic           w_ovf;
  logic           r_ovf;

  // One extra bit of headroom exposes overflow; clamp toward the violated bound.
  always_comb begin
    w_wide = {(ACC_W+1){1'b0}};
    w_sum  = {ACC_W{1'b0}};
    w_ovf  = 1'b0;
    if (in_neg) begin
      w_wide = {w_acc_base[ACC_W-1], w_acc_base} - {1'b0, w_prod_ext};
    end else begin
      w_wide = {w_acc_base[ACC_W-1], w_acc_base} + {1'b0, w_prod_ext};
    end
    if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
      w_ovf = 1'b1;
      w_sum = w_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      w_ovf = 1'b0;
      w_sum = w_wide[ACC_W-1:0];
    end
  end

  assign out_ovf = r_ovf;
`else
  // Plain two's-complement add/subtract, wrapping modulo 2^ACC_W.
  always_comb begin
    w_sum = {ACC_W{1'b0}};
    if (in_neg) begin
      w_sum = w_acc_base - w_prod_ext;
    end else begin
      w_sum = w_acc_base + w_prod_ext;
    end
  end

  assign out_ovf = 1'b0;
`endif

  // Feature FSM: accumulate beats, latch the result on the terminating beat,
  // then hold it until the downstream handshake returns the block to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_acc   <= {ACC_W{1'b0}};
      r_thr   <= {ACC_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 1'b0;
`ifdef FACE_DETECT_ACC_SAT_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_next;
            if (w_first) begin
              r_thr <= thr;
            end
`ifdef FACE_DETECT_ACC_SAT_EN
            r_ovf <= (w_first ? 1'b0 : r_ovf) | w_ovf;
`endif
            if (w_term) begin
              r_state <= ST_HOLD;
              r_valid <= 1'b1;
              r_pass  <= w_pass;
              r_err   <= ~in_last;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 1'b0;
`ifdef FACE_DETECT_ACC_SAT_EN
            r_ovf   <= 1'b0;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_sum   = r_acc;
  assign out_pass  = r_pass;
  assign out_err   = r_err;

endmodule

// File: tb/tb_face_detect_feature_acc.sv
// Self-checking bench for face_detect_feature_acc: directed cases followed by
// randomized features compared against an arithmetic reference model.
module tb_face_detect_feature_acc;

  localparam int PROD_W   = 22;
  localparam int ACC_W    = 26;
  localparam int MAX_RECT = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_neg;
  logic              in_last;
  logic [ACC_W-1:0]  thr;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_pass;
  logic              out_err;
  logic              out_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned b_prod [MAX_RECT+4];
  bit          b_neg  [MAX_RECT+4];
  bit          b_last [MAX_RECT+4];

  face_detect_feature_acc #(
    .PROD_W(PROD_W), .ACC_W(ACC_W), .MAX_RECT(MAX_RECT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_neg(in_neg), .in_last(in_last), .thr(thr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_pass(out_pass), .out_err(out_err), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: one add/subtract in exact arithmetic, then fitted into ACC_W.
  function automatic longint fit(input longint v, output bit ovf);
    longint hi, lo, span, m;
    hi   = (longint'(1) <<< (ACC_W-1)) - 1;
    lo   = -(longint'(1) <<< (ACC_W-1));
    span = longint'(1) <<< ACC_W;
    ovf  = 1'b0;
`ifdef FACE_DETECT_ACC_SAT_EN
    if (v > hi) begin
      ovf = 1'b1;
      return hi;
    end
    if (v < lo) begin
      ovf = 1'b1;
      return lo;
    end
    return v;
`else
    m = v % span;
    if (m < 0) m += span;
    if (m > hi) m -= span;
    return m;
`endif
  endfunction

  task automatic send(input int unsigned prod, input bit neg, input bit last,
                      input longint thr_v);
    int w;
    in_prod  = prod[PROD_W-1:0];
    in_neg   = neg;
    in_last  = last;
    thr      = thr_v[ACC_W-1:0];
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 40) chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_after_release", out_valid, 0);
    chk("ready_after_release", in_ready, 1);
  endtask

  // Send the feature held in b_* (up to its model-predicted end) and check it.
  task automatic run_feature(input int nb, input longint thr_v, input int hold);
    longint acc;
    bit     ovf, o, err, pass;
    int     k;
    acc = 0; ovf = 0; err = 0; k = 0;
    for (int i = 0; i < nb; i++) begin
      acc = fit(b_neg[i] ? acc - longint'(b_prod[i]) : acc + longint'(b_prod[i]), o);
      ovf = ovf | o;
      k = i + 1;
      if (b_last[i]) break;
      if (k == MAX_RECT) begin
        err = 1'b1;
        break;
      end
    end
    pass = (acc >= thr_v);
    for (int i = 0; i < k; i++) begin
      send(b_prod[i], b_neg[i], b_last[i], (i == 0) ? thr_v : longint'($urandom));
      if (i < k - 1) chk("valid_mid_feature", out_valid, 0);
    end
    chk("valid", out_valid, 1);
    chk("sum", $signed(out_sum), acc);
    chk("pass", out_pass, pass);
    chk("err", out_err, err);
    chk("ovf", out_ovf, ovf);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", $signed(out_sum), acc);
      chk("hold_ready", in_ready, 0);
    end
    release_result();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_neg = 1'b0;
    in_last = 1'b0; thr = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", $signed(out_sum), 0);
    chk("rst_pass", out_pass, 0);
    chk("rst_err", out_err, 0);
    chk("rst_ovf", out_ovf, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", in_ready, 1);

    // 1000 - 300 + 200 = 900 against thresholds 850 and 901
    b_prod[0] = 1000; b_neg[0] = 0; b_last[0] = 0;
    b_prod[1] = 300;  b_neg[1] = 1; b_last[1] = 0;
    b_prod[2] = 200;  b_neg[2] = 0; b_last[2] = 1;
    run_feature(3, 850, 0);
    run_feature(3, 901, 1);
    b_prod[0] = 5; b_neg[0] = 1; b_last[0] = 1;
    run_feature(1, -5, 0);

    // Sixteen beats without last: forced end, then a stalled 17th beat
    for (int i = 0; i < MAX_RECT; i++) send(1, 0, 0, 0);
    chk("max_valid", out_valid, 1);
    chk("max_sum", $signed(out_sum), 16);
    chk("max_err", out_err, 1);
    chk("max_pass", out_pass, 1);
    in_prod = 1; in_neg = 0; in_last = 1; thr = '0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", $signed(out_sum), 16);
      chk("stall_err", out_err, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bubble_valid", out_valid, 0);
    chk("bubble_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("after_bubble_valid", out_valid, 1);
    chk("after_bubble_sum", $signed(out_sum), 1);
    chk("after_bubble_err", out_err, 0);
    release_result();

    // Nine large positive products: saturation or wrap depending on build
    for (int i = 0; i < 9; i++) begin
      b_prod[i] = 4194303; b_neg[i] = 0; b_last[i] = (i == 8);
    end
    run_feature(9, 0, 0);

    // Reset in the middle of a feature discards it
    send(100, 0, 0, 0);
    send(200, 0, 0, 0);
    reset_n = 1'b0;
    #2;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sum", $signed(out_sum), 0);
    chk("midrst_err", out_err, 0);
    @(negedge clk); reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("postrst_valid", out_valid, 0);
    end
    b_prod[0] = 7; b_neg[0] = 0; b_last[0] = 1;
    run_feature(1, 0, 0);

    // Reset while a result is pending in HOLD
    b_prod[0] = 9; b_neg[0] = 0; b_last[0] = 1;
    send(9, 0, 1, 0);
    reset_n = 1'b0;
    #2;
    chk("holdrst_valid", out_valid, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("holdrst_ready", in_ready, 1);

    // Randomized features
    for (int f = 0; f < 40; f++) begin
      int nb;
      logic [ACC_W-1:0] t;
      nb = $urandom_range(1, MAX_RECT + 2);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 3) == 0) b_prod[i] = $urandom_range(3145728, 4194303);
        else b_prod[i] = $urandom_range(0, 5000);
        b_neg[i]  = $urandom_range(0, 1) == 1;
        b_last[i] = (i == nb - 1) && (nb <= MAX_RECT);
      end
      t = $urandom;
      if ($urandom_range(0, 1) == 1) t = ACC_W'($urandom_range(0, 20000)) - ACC_W'(10000);
      run_feature(nb, longint'($signed(t)), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
